ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: N, 4, number of requesters; index 0=I0, 1=D0, 2=I1, 3=D1.
REQ-002 Parameter: TIMEOUT, 64, max cycles a single word may wait for ramstate==ACCESS.
REQ-003 Port: CLK  input  1  clock, rising edge.
REQ-004 Port: nRST  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  N  per-requester access request.
REQ-006 Port: wen  input  N  per-requester direction; 1=write, 0=read; sampled with req.
REQ-007 Port: burst  input  N  1=two-word block (addr, addr+4); 0=single word.
REQ-008 Port: addr  input  N x 32  per-requester word address.
REQ-009 Port: store  input  N x 32  per-requester write data; word-2 data presented by the requester after word-1 completes.
REQ-010 Port: ramstate  input  ramstate_t  RAM status (FREE, BUSY, ACCESS, ERROR).
REQ-011 Port: gnt  output  N  one-hot registered grant.
REQ-012 Port: rwait  output  N  per-requester wait; 0 only in the cycle its word completes.
REQ-013 Port: ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-014 Port: ramREN, ramWEN  output  1 each  RAM read and write enables; never both 1.
REQ-015 Port: err, err_id  output  1, 2  sticky error flag and the index of the first failing requester.

Function
REQ-016 States SHALL be IDLE, WORD0, WORD1.
REQ-017 IDLE: if any req is set, the arbiter SHALL grant the first set req searching from ptr upward modulo N, register gnt, and enter WORD0 on the next edge; otherwise it stays in IDLE.
REQ-018 IDLE: gnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0, all rwait=1.
REQ-019 WORD0/WORD1: ramaddr = addr[g] (WORD0) or addr[g]+4 (WORD1), with 32-bit wrap on the addition.
REQ-020 WORD0/WORD1: ramstore=store[g], ramREN=~wen[g], ramWEN=wen[g]; g is the granted index.
REQ-021 rwait[g] SHALL be 0 combinationally when ramstate==ACCESS in WORD0/WORD1; all other rwait bits SHALL stay 1.
REQ-022 WORD0 with ACCESS: go to WORD1 if burst[g], else to IDLE; WORD1 with ACCESS: go to IDLE.
REQ-023 When a transaction ends (complete, abort or timeout), ptr SHALL load (g+1) mod N, giving round-robin fairness.
REQ-024 Back-to-back requests SHALL take exactly one IDLE cycle between transactions.
REQ-025 If req[g] drops during WORD0/WORD1, the arbiter SHALL abort: go to IDLE next edge with enables deasserted from that edge; err is not set.
REQ-026 A per-word cycle counter SHALL clear on entering WORD0/WORD1 and count each cycle without ACCESS.
REQ-027 When the counter reaches TIMEOUT-1 without ACCESS, the arbiter SHALL go to IDLE and set err=1, err_id=g if err was 0.
REQ-028 If ramstate==ERROR in WORD0/WORD1, the arbiter SHALL go to IDLE and set err/err_id as in REQ-027; rwait[g] stays 1.
REQ-029 err SHALL clear only on reset.
REQ-030 Changes on req of non-granted requesters SHALL NOT affect the transaction in flight.
REQ-031 burst and wen SHALL be latched at grant; changes during the transaction are ignored.

Reset
REQ-032 On nRST low, asynchronously: state=IDLE, ptr=0, gnt=0, counter=0, err=0, err_id=0, ramREN=ramWEN=0, rwait=all 1.
REQ-033 Reset asserted mid-burst SHALL abandon the transaction with no further RAM enable.

Verification
REQ-034 req=4'b1111, all single-word reads, ramstate=ACCESS constantly -> grants in order 0,1,2,3,0, each WORD0 one cycle followed by one IDLE cycle.
REQ-035 req[1]=1, wen[1]=1, burst[1]=1, addr[1]=0x100, ramstate BUSY 2 cycles then ACCESS, twice -> ramaddr 0x100 then 0x104, ramWEN=1 throughout, rwait[1]=0 exactly two cycles.
REQ-036 addr[3]=0xFFFFFFFC with burst -> second ramaddr=0x00000000.
REQ-037 Granted requester 2 drops req in WORD1 -> IDLE next edge, ptr=3, err=0.
REQ-038 ramstate held BUSY with TIMEOUT=64 on requester 0 -> exit after 64 cycles, err=1, err_id=0; a later ERROR on requester 2 leaves err_id=0.
REQ-039 nRST pulsed during WORD1 -> outputs at reset values immediately, first post-reset grant searches from index 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter: N requesters share one RAM port, single or two-word bursts.
// Grant is registered one cycle after IDLE sees a request; words stall on ramstate, bounded by TIMEOUT.
package ram_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        wen,
    input  logic [N-1:0]        burst,
    input  logic [N-1:0][31:0]  addr,
    input  logic [N-1:0][31:0]  store,
    input  ramstate_t           ramstate,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        rwait,
    output logic [31:0]         ramaddr,
    output logic [31:0]         ramstore,
    output logic                ramREN,
    output logic                ramWEN,
    output logic                err,
    output logic [1:0]          err_id
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WORD0 = 2'd1;
    localparam logic [1:0] WORD1 = 2'd2;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] g;
    logic [PW-1:0] pick;
    logic [PW-1:0] ptr_inc;
    logic [PW:0]   scan;
    logic          found;
    logic          wen_l;
    logic          burst_l;
    logic [CW-1:0] cnt;
    logic          active;
    logic          fail;
    logic          advance;
    logic          finish;

    assign active  = (state != IDLE);
    assign ptr_inc = (g == PW'(N-1)) ? '0 : g + 1'b1;

    // First requester at or above ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int i = 0; i < N; i++) begin
            scan = {1'b0, ptr} + (PW+1)'(i);
            if (scan >= (PW+1)'(N))
                scan = scan - (PW+1)'(N);
            if (!found && req[scan[PW-1:0]]) begin
                found = 1'b1;
                pick  = scan[PW-1:0];
            end
        end
    end

    // Dropping req aborts cleanly; ERROR or an expired wait is a failure.
    always_comb begin
        fail    = active && req[g] &&
                  ((ramstate == ERROR) ||
                   (ramstate != ACCESS && cnt == CW'(TIMEOUT-1)));
        advance = active && req[g] && (ramstate == ACCESS) &&
                  (state == WORD0) && burst_l;
        finish  = active && (!req[g] || fail ||
                  ((ramstate == ACCESS) && !advance));
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            ptr     <= '0;
            g       <= '0;
            gnt     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            err_id  <= '0;
            wen_l   <= 1'b0;
            burst_l <= 1'b0;
        end else if (state == IDLE) begin
            if (found) begin
                state   <= WORD0;
                g       <= pick;
                gnt     <= {{(N-1){1'b0}}, 1'b1} << pick;
                wen_l   <= wen[pick];
                burst_l <= burst[pick];
                cnt     <= '0;
            end
        end else if (finish) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= ptr_inc;
            cnt   <= '0;
            if (fail && !err) begin
                err    <= 1'b1;
                err_id <= 2'(g);
            end
        end else if (advance) begin
            state <= WORD1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        rwait    = '1;
        ramaddr  = '0;
        ramstore = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        if (active) begin
            ramaddr  = addr[g] + ((state == WORD1) ? 32'd4 : 32'd0);
            ramstore = store[g];
            ramREN   = ~wen_l;
            ramWEN   = wen_l;
            if (ramstate == ACCESS)
                rwait[g] = 1'b0;
        end
    end

endmodule
